// File: rtl/dac_tx_interleaver.sv
// Converts the filtered Q1.15 estimate stream to 14-bit offset-binary DAC codes and
// interleaves it (channel A) with chb_dat_i (channel B) on a shared DAC bus.
module dac_tx_interleaver #(
    parameter int DEPTH   = 4,
    parameter int RATE    = 2,
    parameter int RST_CYC = 4
) (
    input  logic                     adc_clk_i,
    input  logic                     adc_rst_i,
    input  logic                     enable_i,
    input  logic [15:0]              x_dat_i,
    input  logic                     x_valid_i,
    output logic                     x_ready_o,
    input  logic [15:0]              chb_dat_i,
    output logic [13:0]              dac_dat_o,
    output logic                     dac_sel_o,
    output logic                     dac_wrt_o,
    output logic                     dac_rst_o,
    output logic                     underflow_o,
    output logic [15:0]              underflow_cnt_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (RATE > 2) ? $clog2(RATE) : 1;
    localparam int RW = $clog2(RST_CYC + 1);
    localparam logic [13:0] MIDSCALE = 14'h2000;

    typedef enum logic [1:0] {
        S_RST_HOLD = 2'd0,
        S_IDLE     = 2'd1,
        S_RUN      = 2'd2
    } state_t;

    // Round (+2), drop two LSBs arithmetically, saturate to 14-bit signed, flip MSB.
    function automatic logic [13:0] conv(input logic [15:0] s);
        logic signed [16:0] r;
        logic signed [14:0] t;
        logic [13:0]        code;
        r = $signed({s[15], s}) + 17'sd2;
        t = r[16:2];
        if (t > 15'sd8191) begin
            code = 14'h3FFF;
        end else if (t < -15'sd8192) begin
            code = 14'h0000;
        end else begin
            code = {~t[13], t[12:0]};
        end
        return code;
    endfunction

    state_t          state_q, state_d;
    logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_nxt;
    logic [13:0]     dat_q, dat_d;
    logic            sel_q, sel_d;
    logic            wrt_q, wrt_d;
    logic            dac_rst_q, dac_rst_d;
    logic            uf_q, uf_d;
    logic [15:0]     ucnt_q, ucnt_d;
    logic [15:0]     held_q, held_d;
    logic [15:0]     chb_q, chb_d;

    logic [15:0]     mem_q [DEPTH];
    logic [LW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level;
    logic            full, empty, push, pop, frame_start;
    logic [15:0]     head;

    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign push  = x_valid_i & ~full;
    assign pop   = frame_start & ~empty;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign cnt_nxt = (cnt_q == CW'(RATE - 1)) ? '0 : cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        cnt_d       = cnt_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        wrt_d       = 1'b0;
        dac_rst_d   = dac_rst_q;
        uf_d        = uf_q;
        ucnt_d      = ucnt_q;
        held_d      = held_q;
        chb_d       = chb_q;
        frame_start = 1'b0;

        case (state_q)
            S_RST_HOLD: begin
                dac_rst_d = 1'b1;
                dat_d     = MIDSCALE;
                sel_d     = 1'b0;
                cnt_d     = '0;
                if (rst_cnt_q == RW'(RST_CYC - 1)) begin
                    state_d   = S_IDLE;
                    dac_rst_d = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            S_IDLE: begin
                dac_rst_d = 1'b0;
                dat_d     = MIDSCALE;
                sel_d     = 1'b0;
                cnt_d     = '0;
                if (enable_i) begin
                    frame_start = 1'b1;
                    state_d     = S_RUN;
                    cnt_d       = CW'(1);
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    if (enable_i) begin
                        frame_start = 1'b1;
                        cnt_d       = cnt_nxt;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        dat_d   = MIDSCALE;
                        sel_d   = 1'b0;
                    end
                end else if (cnt_q == CW'(1)) begin
                    dat_d = conv(chb_q);
                    sel_d = 1'b1;
                    wrt_d = 1'b1;
                    cnt_d = cnt_nxt;
                end else begin
                    cnt_d = cnt_nxt;
                end
            end
            default: begin
                state_d = S_RST_HOLD;
            end
        endcase

        // Channel A write; an empty FIFO repeats the last A sample and logs an underflow.
        if (frame_start) begin
            chb_d = chb_dat_i;
            sel_d = 1'b0;
            wrt_d = 1'b1;
            if (!empty) begin
                dat_d  = conv(head);
                held_d = head;
            end else begin
                dat_d = conv(held_q);
                uf_d  = 1'b1;
                if (ucnt_q != 16'hFFFF) begin
                    ucnt_d = ucnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            state_q   <= S_RST_HOLD;
            rst_cnt_q <= '0;
            cnt_q     <= '0;
            dat_q     <= MIDSCALE;
            sel_q     <= 1'b0;
            wrt_q     <= 1'b0;
            dac_rst_q <= 1'b1;
            uf_q      <= 1'b0;
            ucnt_q    <= '0;
            held_q    <= '0;
            chb_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            cnt_q     <= cnt_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            wrt_q     <= wrt_d;
            dac_rst_q <= dac_rst_d;
            uf_q      <= uf_d;
            ucnt_q    <= ucnt_d;
            held_q    <= held_d;
            chb_q     <= chb_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + LW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + LW'(1);
            end
        end
    end

    always_ff @(posedge adc_clk_i) begin
        if (!adc_rst_i && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= x_dat_i;
        end
    end

    assign x_ready_o       = ~full;
    assign dac_dat_o       = dat_q;
    assign dac_sel_o       = sel_q;
    assign dac_wrt_o       = wrt_q;
    assign dac_rst_o       = dac_rst_q;
    assign underflow_o     = uf_q;
    assign underflow_cnt_o = ucnt_q;
    assign fifo_level_o    = level;

endmodule

// File: tb/tb_dac_tx_interleaver.sv
// Directed bench for dac_tx_interleaver (RATE = 4 so the idle slots of a frame are visible).
module tb_dac_tx_interleaver;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] x_dat;
    logic        x_valid;
    logic        x_ready;
    logic [15:0] chb;
    logic [13:0] dac_dat;
    logic        dac_sel;
    logic        dac_wrt;
    logic        dac_rst;
    logic        underflow;
    logic [15:0] ucnt;
    logic [2:0]  level;

    int pass_cnt  = 0;
    int check_cnt = 0;

    always #5 clk = ~clk;

    dac_tx_interleaver #(.DEPTH(4), .RATE(4), .RST_CYC(4)) dut (
        .adc_clk_i       (clk),
        .adc_rst_i       (rst),
        .enable_i        (enable),
        .x_dat_i         (x_dat),
        .x_valid_i       (x_valid),
        .x_ready_o       (x_ready),
        .chb_dat_i       (chb),
        .dac_dat_o       (dac_dat),
        .dac_sel_o       (dac_sel),
        .dac_wrt_o       (dac_wrt),
        .dac_rst_o       (dac_rst),
        .underflow_o     (underflow),
        .underflow_cnt_o (ucnt),
        .fifo_level_o    (level)
    );

    // Presents one sample for one rising edge; caller is at a falling edge.
    task automatic push_sample(input logic [15:0] v);
        x_valid = 1'b1;
        x_dat   = v;
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    task automatic test_reset;
        int hi;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_cnt++; if (dac_rst !== 1'b1 || dac_wrt !== 1'b0 || dac_dat !== 14'h2000) $display("FAIL rst_during: rst=%b wrt=%b dat=%h want 1 0 2000", dac_rst, dac_wrt, dac_dat); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hi = 0;
        for (int j = 0; j < 12; j++) begin
            if (dac_rst !== 1'b1) break;
            hi++;
            @(negedge clk);
        end
        check_cnt++; if (hi !== 4) $display("FAIL rst_hold_len: got %0d want 4", hi); else pass_cnt++;
        check_cnt++; if (dac_dat !== 14'h2000 || dac_wrt !== 1'b0 || dac_sel !== 1'b0) $display("FAIL rst_idle_out: dat=%h wrt=%b sel=%b want 2000 0 0", dac_dat, dac_wrt, dac_sel); else pass_cnt++;
        check_cnt++; if (x_ready !== 1'b1 || level !== 3'd0) $display("FAIL rst_fifo: ready=%b level=%0d want 1 0", x_ready, level); else pass_cnt++;
        check_cnt++; if (underflow !== 1'b0 || ucnt !== 16'd0) $display("FAIL rst_uf: uf=%b cnt=%0d want 0 0", underflow, ucnt); else pass_cnt++;
    endtask

    task automatic test_conversion;
        logic [13:0] exp_a [4];
        int a_idx;
        int b_cnt;
        exp_a[0] = 14'h2000; exp_a[1] = 14'h2002; exp_a[2] = 14'h3FFF; exp_a[3] = 14'h0000;
        chb = 16'hFFFC;
        push_sample(16'h0000);
        push_sample(16'h0006);
        push_sample(16'h7FFF);
        push_sample(16'h8000);
        check_cnt++; if (level !== 3'd4 || x_ready !== 1'b0) $display("FAIL conv_fill: level=%0d ready=%b want 4 0", level, x_ready); else pass_cnt++;
        enable = 1'b1;
        a_idx = 0;
        b_cnt = 0;
        for (int j = 0; j < 40 && b_cnt < 4; j++) begin
            @(negedge clk);
            if (dac_wrt === 1'b1 && dac_sel === 1'b0) begin
                check_cnt++; if (dac_dat !== exp_a[a_idx]) $display("FAIL conv_a%0d: got %h want %h", a_idx, dac_dat, exp_a[a_idx]); else pass_cnt++;
                a_idx++;
                if (a_idx == 4) enable = 1'b0;
            end else if (dac_wrt === 1'b1) begin
                check_cnt++; if (dac_dat !== 14'h1FFF) $display("FAIL conv_b%0d: got %h want 1fff", b_cnt, dac_dat); else pass_cnt++;
                b_cnt++;
            end
        end
        check_cnt++; if (a_idx !== 4 || b_cnt !== 4) $display("FAIL conv_writes: a=%0d b=%0d want 4 4", a_idx, b_cnt); else pass_cnt++;
        repeat (4) @(negedge clk);
        check_cnt++; if (dac_dat !== 14'h2000 || dac_wrt !== 1'b0 || underflow !== 1'b0) $display("FAIL conv_idle: dat=%h wrt=%b uf=%b want 2000 0 0", dac_dat, dac_wrt, underflow); else pass_cnt++;
    endtask

    task automatic test_framing;
        logic [13:0] exp_a [3];
        logic [13:0] exp_d;
        int ph;
        exp_a[0] = 14'h2400; exp_a[1] = 14'h2800; exp_a[2] = 14'h1C00;
        chb = 16'h0100;
        push_sample(16'h1000);
        push_sample(16'h2000);
        push_sample(16'hF000);
        enable = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i < 12) begin
                ph = i % 4;
                exp_d = (ph == 0) ? exp_a[i / 4] : 14'h2040;
                check_cnt++; if (dac_wrt !== (ph < 2) || dac_sel !== (ph != 0) || dac_dat !== exp_d) $display("FAIL frame_c%0d: wrt=%b sel=%b dat=%h want %b %b %h", i, dac_wrt, dac_sel, dac_dat, ph < 2, ph != 0, exp_d); else pass_cnt++;
                if (ph == 0) begin
                    check_cnt++; if (level !== 3'(2 - i / 4)) $display("FAIL frame_level%0d: got %0d want %0d", i, level, 2 - i / 4); else pass_cnt++;
                end
            end else begin
                check_cnt++; if (dac_wrt !== 1'b0 || dac_dat !== 14'h2000) $display("FAIL frame_stop%0d: wrt=%b dat=%h want 0 2000", i, dac_wrt, dac_dat); else pass_cnt++;
            end
            if (i == 9) enable = 1'b0;
        end
        check_cnt++; if (underflow !== 1'b0) $display("FAIL frame_uf: got %b want 0", underflow); else pass_cnt++;
    endtask

    task automatic test_underflow;
        chb = 16'h0000;
        push_sample(16'h4000);
        enable = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i % 4 == 0 && i < 16) begin
                check_cnt++; if (dac_dat !== 14'h3000 || dac_wrt !== 1'b1 || dac_sel !== 1'b0) $display("FAIL uf_a%0d: dat=%h wrt=%b sel=%b want 3000 1 0", i, dac_dat, dac_wrt, dac_sel); else pass_cnt++;
            end
            if (i == 0) begin
                check_cnt++; if (underflow !== 1'b0 || ucnt !== 16'd0) $display("FAIL uf_first: uf=%b cnt=%0d want 0 0", underflow, ucnt); else pass_cnt++;
            end
            if (i == 4) begin
                check_cnt++; if (underflow !== 1'b1 || ucnt !== 16'd1) $display("FAIL uf_second: uf=%b cnt=%0d want 1 1", underflow, ucnt); else pass_cnt++;
            end
            if (i == 13) enable = 1'b0;
        end
        check_cnt++; if (ucnt !== 16'd3 || underflow !== 1'b1 || dac_wrt !== 1'b0 || dac_dat !== 14'h2000) $display("FAIL uf_end: cnt=%0d uf=%b wrt=%b dat=%h want 3 1 0 2000", ucnt, underflow, dac_wrt, dac_dat); else pass_cnt++;
    endtask

    task automatic test_full_and_reset;
        logic [15:0] vals [5];
        vals[0] = 16'h0000; vals[1] = 16'h0004; vals[2] = 16'h0008; vals[3] = 16'hFFF8; vals[4] = 16'h7FFF;
        for (int k = 0; k < 5; k++) begin
            check_cnt++; if (x_ready !== (k < 4) || level !== 3'(k)) $display("FAIL full_push%0d: ready=%b level=%0d want %b %0d", k, x_ready, level, k < 4, k); else pass_cnt++;
            x_valid = 1'b1;
            x_dat   = vals[k];
            @(negedge clk);
        end
        x_valid = 1'b0;
        check_cnt++; if (x_ready !== 1'b0 || level !== 3'd4) $display("FAIL full_hold: ready=%b level=%0d want 0 4", x_ready, level); else pass_cnt++;
        enable = 1'b1;
        @(negedge clk);
        check_cnt++; if (x_ready !== 1'b1 || level !== 3'd3 || dac_dat !== 14'h2000 || dac_wrt !== 1'b1) $display("FAIL full_pop1: ready=%b level=%0d dat=%h wrt=%b want 1 3 2000 1", x_ready, level, dac_dat, dac_wrt); else pass_cnt++;
        repeat (4) @(negedge clk);
        check_cnt++; if (level !== 3'd2 || dac_dat !== 14'h2001) $display("FAIL full_pop2: level=%0d dat=%h want 2 2001", level, dac_dat); else pass_cnt++;
        // Reset while running with two samples still queued.
        rst = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check_cnt++; if (dac_dat !== 14'h2000 || dac_sel !== 1'b0 || dac_wrt !== 1'b0 || dac_rst !== 1'b1) $display("FAIL rst_run_out: dat=%h sel=%b wrt=%b rst=%b want 2000 0 0 1", dac_dat, dac_sel, dac_wrt, dac_rst); else pass_cnt++;
        check_cnt++; if (level !== 3'd0 || x_ready !== 1'b1 || underflow !== 1'b0 || ucnt !== 16'd0) $display("FAIL rst_run_state: level=%0d ready=%b uf=%b cnt=%0d want 0 1 0 0", level, x_ready, underflow, ucnt); else pass_cnt++;
        rst = 1'b0;
        for (int j = 0; j < 12 && dac_rst === 1'b1; j++) @(negedge clk);
        check_cnt++; if (dac_rst !== 1'b0) $display("FAIL rst_run_release: dac_rst=%b want 0", dac_rst); else pass_cnt++;
        enable = 1'b1;
        @(negedge clk);
        check_cnt++; if (underflow !== 1'b1 || ucnt !== 16'd1 || dac_wrt !== 1'b1 || dac_sel !== 1'b0) $display("FAIL rst_run_lost: uf=%b cnt=%0d wrt=%b sel=%b want 1 1 1 0", underflow, ucnt, dac_wrt, dac_sel); else pass_cnt++;
        enable = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        x_dat   = 16'h0000;
        x_valid = 1'b0;
        chb     = 16'h0000;
        test_reset();
        test_conversion();
        test_framing();
        test_underflow();
        test_full_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
